// File: rtl/saturn_alu_pkg.sv
// Shared definitions for the nibble-serial Saturn ALU: op codes, FSM states
// and the per-nibble add/subtract helper (hex or BCD).
package saturn_alu_pkg;

    localparam logic [4:0] OP_ZERO   = 5'd0;
    localparam logic [4:0] OP_COPY   = 5'd1;
    localparam logic [4:0] OP_ADD    = 5'd2;
    localparam logic [4:0] OP_SUB    = 5'd3;
    localparam logic [4:0] OP_INC    = 5'd4;
    localparam logic [4:0] OP_DEC    = 5'd5;
    localparam logic [4:0] OP_TWOCMP = 5'd6;
    localparam logic [4:0] OP_ONECMP = 5'd7;
    localparam logic [4:0] OP_AND    = 5'd8;
    localparam logic [4:0] OP_OR     = 5'd9;
    localparam logic [4:0] OP_SET_P  = 5'd10;
    localparam logic [4:0] OP_INC_P  = 5'd11;
    localparam logic [4:0] OP_DEC_P  = 5'd12;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // P-register ops bypass the nibble loop entirely.
    function automatic logic is_p_op(input logic [4:0] op);
        return (op == OP_SET_P) || (op == OP_INC_P) || (op == OP_DEC_P);
    endfunction

    // One nibble of ripple add/sub. Returns {carry_or_borrow, digit}.
    // Decimal mode folds the digit back into 0..9 with the same rule for
    // every input, so non-BCD digits simply produce a wrapped value.
    function automatic logic [4:0] nib_addsub(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic       cin,
                                              input logic       sub,
                                              input logic       dec);
        logic [5:0] t;
        logic [4:0] r;
        if (!sub) begin
            t = {2'b00, a} + {2'b00, b} + {5'b00000, cin};
            if (dec) begin
                if (t >= 6'd10) begin
                    r = {1'b1, 4'(t - 6'd10)};
                end else begin
                    r = {1'b0, t[3:0]};
                end
            end else begin
                r = {t[4], t[3:0]};
            end
        end else begin
            t = {2'b00, a} - {2'b00, b} - {5'b00000, cin};
            if (t[5]) begin
                r = {1'b1, 4'(t + (dec ? 6'd10 : 6'd16))};
            end else begin
                r = {1'b0, t[3:0]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/saturn_alu_nibble.sv
// Combinational single-nibble ALU slice with carry/borrow in and out.
module saturn_alu_nibble
    import saturn_alu_pkg::*;
(
    input  logic [4:0] i_op,
    input  logic       i_dec,
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_r,
    output logic       o_cout
);

    logic [3:0] w_max;
    logic [4:0] w_add;
    logic [4:0] w_sub;

    assign w_max = i_dec ? 4'd9 : 4'd15;
    assign w_add = nib_addsub(i_a, (i_op == OP_INC) ? 4'd0 : i_b, i_cin, 1'b0, i_dec);
    assign w_sub = nib_addsub(i_a, i_b, i_cin, 1'b1, i_dec);

    // Select the nibble result and outgoing carry for the current op.
    // For TWOCMP the carry chain means "+1 still pending" (all lower nibbles zero).
    always_comb begin
        o_r    = i_a;
        o_cout = i_cin;
        case (i_op)
            OP_ZERO: begin
                o_r = 4'd0;
            end
            OP_COPY: begin
                o_r = i_b;
            end
            OP_ADD, OP_INC: begin
                o_r    = w_add[3:0];
                o_cout = w_add[4];
            end
            OP_SUB, OP_DEC: begin
                o_r    = w_sub[3:0];
                o_cout = w_sub[4];
            end
            OP_TWOCMP: begin
                if (i_cin && (i_a == 4'd0)) begin
                    o_r    = 4'd0;
                    o_cout = 1'b1;
                end else begin
                    o_r    = w_max - i_a + {3'b000, i_cin};
                    o_cout = 1'b0;
                end
            end
            OP_ONECMP: begin
                o_r    = w_max - i_a;
                o_cout = 1'b0;
            end
            OP_AND: begin
                o_r = i_a & i_b;
            end
            OP_OR: begin
                o_r = i_a | i_b;
            end
            default: begin
                o_r    = i_a;
                o_cout = i_cin;
            end
        endcase
    end

endmodule

// File: rtl/saturn_alu_serial.sv
// Nibble-serial Saturn ALU: walks a (possibly wrapping) nibble field one
// nibble per clock, owns the P pointer and the carry flag.
module saturn_alu_serial
    import saturn_alu_pkg::*;
#(
    parameter int NIBBLES = 16,
    parameter int P_RESET = 3,
    parameter int IW      = $clog2(NIBBLES)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [4:0]           i_alu_op,
    input  logic                 i_dec,
    input  logic [IW-1:0]        i_field_start,
    input  logic [IW-1:0]        i_field_last,
    input  logic [4*NIBBLES-1:0] i_src_a,
    input  logic [4*NIBBLES-1:0] i_src_b,
    input  logic [3:0]           i_p_value,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [4*NIBBLES-1:0] o_result,
    output logic                 o_carry,
    output logic [3:0]           o_reg_p
);

    localparam int W = 4 * NIBBLES;

    state_t        r_state;
    state_t        w_state_next;
    logic [4:0]    r_op;
    logic          r_dec;
    logic [IW-1:0] r_start;
    logic [IW-1:0] r_last;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_work;
    logic [W-1:0]  r_result;
    logic          r_cin;
    logic          r_carry;
    logic [3:0]    r_p;
    logic [3:0]    r_pval;

    logic [3:0]    w_nib_a;
    logic [3:0]    w_nib_b;
    logic [3:0]    w_nib_r;
    logic          w_cout;
    logic [W-1:0]  w_work_next;

    assign w_nib_a = r_work[{r_idx, 2'b00} +: 4];

    // DEC is a subtract of 1 injected at the first nibble of the field.
    always_comb begin
        if (r_op == OP_DEC) begin
            w_nib_b = (r_idx == r_start) ? 4'd1 : 4'd0;
        end else begin
            w_nib_b = r_b[{r_idx, 2'b00} +: 4];
        end
    end

    saturn_alu_nibble u_nibble (
        .i_op   (r_op),
        .i_dec  (r_dec),
        .i_a    (w_nib_a),
        .i_b    (w_nib_b),
        .i_cin  (r_cin),
        .o_r    (w_nib_r),
        .o_cout (w_cout)
    );

    // Working register with the current nibble replaced by the slice result.
    always_comb begin
        w_work_next = r_work;
        w_work_next[{r_idx, 2'b00} +: 4] = w_nib_r;
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: P ops skip the nibble loop; CALC ends after the last nibble.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = is_p_op(i_alu_op) ? S_DONE : S_CALC;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (r_idx == r_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_CALC;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand latch, nibble walk, result/carry publish, P update.
    // Result and carry are written on the edge entering DONE so they are valid
    // with the done pulse; P is written on the edge leaving DONE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op     <= OP_ZERO;
            r_dec    <= 1'b0;
            r_start  <= '0;
            r_last   <= '0;
            r_idx    <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_result <= '0;
            r_cin    <= 1'b0;
            r_carry  <= 1'b0;
            r_p      <= 4'(P_RESET);
            r_pval   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op    <= i_alu_op;
                        r_dec   <= i_dec;
                        r_start <= i_field_start;
                        r_last  <= i_field_last;
                        r_idx   <= i_field_start;
                        r_b     <= i_src_b;
                        r_work  <= i_src_a;
                        r_pval  <= i_p_value;
                        r_cin   <= (i_alu_op == OP_INC) || (i_alu_op == OP_TWOCMP);
                        if (is_p_op(i_alu_op)) begin
                            r_result <= i_src_a;
                            case (i_alu_op)
                                OP_INC_P: r_carry <= (r_p == 4'd15);
                                OP_DEC_P: r_carry <= (r_p == 4'd0);
                                default:  r_carry <= r_carry;
                            endcase
                        end
                    end
                end
                S_CALC: begin
                    r_work <= w_work_next;
                    r_idx  <= r_idx + IW'(1);
                    r_cin  <= w_cout;
                    if (r_idx == r_last) begin
                        r_result <= w_work_next;
                        case (r_op)
                            OP_ADD, OP_SUB, OP_INC, OP_DEC: r_carry <= w_cout;
                            OP_TWOCMP:                      r_carry <= ~w_cout;
                            OP_ONECMP:                      r_carry <= 1'b0;
                            default:                        r_carry <= r_carry;
                        endcase
                    end
                end
                S_DONE: begin
                    case (r_op)
                        OP_SET_P: r_p <= r_pval;
                        OP_INC_P: r_p <= r_p + 4'd1;
                        OP_DEC_P: r_p <= r_p - 4'd1;
                        default:  r_p <= r_p;
                    endcase
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign o_busy   = (r_state != S_IDLE);
    assign o_done   = (r_state == S_DONE);
    assign o_result = r_result;
    assign o_carry  = r_carry;
    assign o_reg_p  = r_p;

endmodule

// File: tb/tb_saturn_alu_serial.sv
// Directed self-checking bench for saturn_alu_serial (NIBBLES=16).
module tb_saturn_alu_serial;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  alu_op;
    logic        dec;
    logic [3:0]  fstart;
    logic [3:0]  flast;
    logic [63:0] src_a;
    logic [63:0] src_b;
    logic [3:0]  p_value;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        carry;
    logic [3:0]  reg_p;

    int checks   = 0;
    int failures = 0;

    saturn_alu_serial #(.NIBBLES(16), .P_RESET(3)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_alu_op      (alu_op),
        .i_dec         (dec),
        .i_field_start (fstart),
        .i_field_last  (flast),
        .i_src_a       (src_a),
        .i_src_b       (src_b),
        .i_p_value     (p_value),
        .o_busy        (busy),
        .o_done        (done),
        .o_result      (result),
        .o_carry       (carry),
        .o_reg_p       (reg_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start an op in the current cycle (cycle 0), wait for done, report its
    // cycle number (0 on timeout), then step one cycle into IDLE.
    task automatic do_op(input logic [4:0] op, input logic d, input logic [3:0] fs,
                         input logic [3:0] fl, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] pv, output int lat);
        alu_op = op; dec = d; fstart = fs; flast = fl;
        src_a = a; src_b = b; p_value = pv; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            tick();
        end
        tick();
    endtask

    int lat;
    int dcnt;
    int dfirst;

    initial begin
        rst = 1'b1; start = 1'b0; alu_op = 5'd0; dec = 1'b0;
        fstart = 4'd0; flast = 4'd0; src_a = 64'd0; src_b = 64'd0; p_value = 4'd0;
        #1;
        tick(); tick();
        rst = 1'b0;
        check("rst_result", result, 64'd0);
        check("rst_carry",  {63'd0, carry}, 64'd0);
        check("rst_busy",   {63'd0, busy},  64'd0);
        check("rst_done",   {63'd0, done},  64'd0);
        check("rst_p",      {60'd0, reg_p}, 64'd3);

        // Hex ADD, field 0..1
        do_op(5'd2, 1'b0, 4'd0, 4'd1, 64'hFEDC_BA98_7654_3209, 64'h1111_1111_1111_1108, 4'd0, lat);
        check("hadd_res",   result, 64'hFEDC_BA98_7654_3211);
        check("hadd_carry", {63'd0, carry}, 64'd0);
        check("hadd_lat",   64'(lat), 64'd3);

        // Decimal ADD 99 + 01
        do_op(5'd2, 1'b1, 4'd0, 4'd1, 64'h99, 64'h01, 4'd0, lat);
        check("dadd_res",   result, 64'h0);
        check("dadd_carry", {63'd0, carry}, 64'd1);

        // Hex SUB 0000 - 0001
        do_op(5'd3, 1'b0, 4'd0, 4'd3, 64'h0, 64'h1, 4'd0, lat);
        check("hsub_res",   result, 64'h0000_0000_0000_FFFF);
        check("hsub_carry", {63'd0, carry}, 64'd1);
        check("hsub_lat",   64'(lat), 64'd5);

        // Wrapping COPY 15..0
        do_op(5'd1, 1'b0, 4'd15, 4'd0, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 4'd0, lat);
        check("wcopy_res",   result, 64'hA555_5555_5555_555A);
        check("wcopy_lat",   64'(lat), 64'd3);
        check("wcopy_carry", {63'd0, carry}, 64'd1);

        // Single-nibble COPY 7..7
        do_op(5'd1, 1'b0, 4'd7, 4'd7, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 4'd0, lat);
        check("scopy_res", result, 64'h5555_5555_A555_5555);
        check("scopy_lat", 64'(lat), 64'd2);

        // ZERO field 4..7, carry unchanged
        do_op(5'd0, 1'b0, 4'd4, 4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'd0, lat);
        check("zero_res",   result, 64'hFFFF_FFFF_0000_FFFF);
        check("zero_carry", {63'd0, carry}, 64'd1);

        // Decimal SUB 10 - 01
        do_op(5'd3, 1'b1, 4'd0, 4'd1, 64'h10, 64'h01, 4'd0, lat);
        check("dsub_res",   result, 64'h09);
        check("dsub_carry", {63'd0, carry}, 64'd0);

        // INC / DEC hex
        do_op(5'd4, 1'b0, 4'd0, 4'd2, 64'h0FF, 64'h0, 4'd0, lat);
        check("inc_res",   result, 64'h100);
        check("inc_carry", {63'd0, carry}, 64'd0);
        do_op(5'd5, 1'b0, 4'd0, 4'd2, 64'h100, 64'h0, 4'd0, lat);
        check("dec_res",   result, 64'h0FF);

        // TWOCMP nonzero and zero
        do_op(5'd6, 1'b0, 4'd0, 4'd3, 64'h0001, 64'h0, 4'd0, lat);
        check("tc_res",   result, 64'hFFFF);
        check("tc_carry", {63'd0, carry}, 64'd1);
        // AND keeps carry
        do_op(5'd8, 1'b0, 4'd0, 4'd3, 64'hF0F0, 64'hFF00, 4'd0, lat);
        check("and_res",   result, 64'hF000);
        check("and_carry", {63'd0, carry}, 64'd1);
        do_op(5'd6, 1'b0, 4'd0, 4'd3, 64'h0, 64'h0, 4'd0, lat);
        check("tc0_res",   result, 64'h0);
        check("tc0_carry", {63'd0, carry}, 64'd0);

        // ONECMP decimal
        do_op(5'd9, 1'b0, 4'd0, 4'd0, 64'h0, 64'h1, 4'd0, lat);
        check("or_carry", {63'd0, carry}, 64'd0);
        do_op(5'd7, 1'b1, 4'd0, 4'd1, 64'h12, 64'h0, 4'd0, lat);
        check("onec_res", result, 64'h87);

        // No-op code returns A
        do_op(5'd20, 1'b0, 4'd0, 4'd3, 64'h1234, 64'hFFFF, 4'd0, lat);
        check("nop_res", result, 64'h1234);
        check("nop_lat", 64'(lat), 64'd5);

        // P ops
        do_op(5'd10, 1'b0, 4'd0, 4'd0, 64'h0, 64'h0, 4'd15, lat);
        check("setp15_p",   {60'd0, reg_p}, 64'd15);
        check("setp15_lat", 64'(lat), 64'd1);
        do_op(5'd11, 1'b0, 4'd0, 4'd0, 64'hDEAD_BEEF_0000_1111, 64'h0, 4'd0, lat);
        check("incp_p",     {60'd0, reg_p}, 64'd0);
        check("incp_carry", {63'd0, carry}, 64'd1);
        check("incp_lat",   64'(lat), 64'd1);
        check("incp_res",   result, 64'hDEAD_BEEF_0000_1111);
        do_op(5'd12, 1'b0, 4'd0, 4'd0, 64'h0, 64'h0, 4'd0, lat);
        check("decp_p",     {60'd0, reg_p}, 64'd15);
        check("decp_carry", {63'd0, carry}, 64'd1);
        do_op(5'd10, 1'b0, 4'd0, 4'd0, 64'h0, 64'h0, 4'd7, lat);
        check("setp7_p",     {60'd0, reg_p}, 64'd7);
        check("setp7_carry", {63'd0, carry}, 64'd1);
        do_op(5'd12, 1'b0, 4'd0, 4'd0, 64'h0, 64'h0, 4'd0, lat);
        check("decp6_p",     {60'd0, reg_p}, 64'd6);
        check("decp6_carry", {63'd0, carry}, 64'd0);

        // Reset during the 3rd CALC cycle of a 16-nibble ADD
        alu_op = 5'd2; dec = 1'b0; fstart = 4'd0; flast = 4'd15;
        src_a = 64'h1111_1111_1111_1111; src_b = 64'h2222_2222_2222_2222; start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_busy_c1", {63'd0, busy}, 64'd1);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",   {63'd0, busy}, 64'd0);
        check("abort_done",   {63'd0, done}, 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_p",      {60'd0, reg_p}, 64'd3);
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) dcnt++;
            tick();
        end
        check("abort_nodone", 64'(dcnt), 64'd0);

        // Start while busy is ignored
        alu_op = 5'd2; dec = 1'b0; fstart = 4'd0; flast = 4'd3;
        src_a = 64'h1; src_b = 64'h2; start = 1'b1;
        tick();
        start = 1'b0;
        dcnt = 0; dfirst = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) begin
                alu_op = 5'd0; src_a = 64'hFFFF; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dcnt++;
                if (dfirst == 0) dfirst = k;
            end
            tick();
        end
        start = 1'b0;
        check("ign_done_cnt",   64'(dcnt),   64'd1);
        check("ign_done_cycle", 64'(dfirst), 64'd5);
        check("ign_result",     result, 64'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
